// File: rtl/xsleena_video_timing_pkg.sv
// Shared raster defaults and helpers for the Xain'd Sleena video timing block.
package xsleena_video_pkg;

  localparam int COUNT_W = 9;

  localparam int H_TOTAL_DEF      = 384;
  localparam int H_ACTIVE_DEF     = 256;
  localparam int H_SYNC_START_DEF = 304;
  localparam int H_SYNC_LEN_DEF   = 32;
  localparam int V_TOTAL_DEF      = 272;
  localparam int V_ACTIVE_DEF     = 240;
  localparam int V_SYNC_START_DEF = 248;
  localparam int V_SYNC_LEN_DEF   = 8;
  localparam int CEN_PERIOD_DEF   = 8;
  localparam int CEN_TIMEOUT_DEF  = 64;

  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic {
    MON_IDLE,
    MON_ARMED
  } mon_state_e;

  function automatic logic in_window(input count_t c, input int start, input int len);
    return (int'(c) >= start) && (int'(c) < start + len);
  endfunction

endpackage

// File: rtl/xsleena_video_timing_cen_monitor.sv
// Watches the pixel enable for regular spacing; pulses on a bad interval and
// latches a fault on any bad interval or stall until reset.
module xsleena_cen_monitor
  import xsleena_video_pkg::*;
#(
  parameter int CEN_PERIOD  = CEN_PERIOD_DEF,
  parameter int CEN_TIMEOUT = CEN_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pix_cen,
  output logic o_cen_err,
  output logic o_cen_fault
);

  localparam int GAP_W = $clog2(CEN_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CEN_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_EXP = GAP_W'(CEN_PERIOD);

  mon_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_q, err_d;
  logic             fault_q, fault_d;

  // gap_q holds the number of edges since the last enable, so it equals the
  // interval when the next enable is sampled; it saturates at the timeout.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    fault_d = fault_q;
    if (i_pix_cen) begin
      gap_d   = GAP_ONE;
      state_d = MON_ARMED;
      if (state_q == MON_ARMED && gap_q != GAP_EXP) begin
        err_d   = 1'b1;
        fault_d = 1'b1;
      end
    end else if (gap_q == GAP_MAX) begin
      fault_d = 1'b1;
    end else begin
      gap_d = gap_q + GAP_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= MON_IDLE;
      gap_q   <= GAP_ONE;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  assign o_cen_err   = err_q;
  assign o_cen_fault = fault_q;

endmodule

// File: rtl/xsleena_video_timing.sv
// Raster counters, blanking, syncs and line/frame strobes driven by the
// 1-in-8 pixel enable, plus a health monitor on that enable.
module xsleena_video_timing
  import xsleena_video_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_LEN   = V_SYNC_LEN_DEF,
  parameter int CEN_PERIOD   = CEN_PERIOD_DEF,
  parameter int CEN_TIMEOUT  = CEN_TIMEOUT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_cen,
  output logic [COUNT_W-1:0] o_hcnt,
  output logic [COUNT_W-1:0] o_vcnt,
  output logic               o_hblank,
  output logic               o_vblank,
  output logic               o_hsync_n,
  output logic               o_vsync_n,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic               o_cen_err,
  output logic               o_cen_fault
);

  if (H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL ||
      H_SYNC_START + H_SYNC_LEN > H_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL ||
      H_TOTAL > (1 << COUNT_W) || V_TOTAL > (1 << COUNT_W) ||
      CEN_PERIOD < 1 || CEN_PERIOD >= CEN_TIMEOUT) begin : g_bad_params
    $error("xsleena_video_timing: illegal raster or enable parameters");
  end

  localparam count_t H_LAST = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST = count_t'(V_TOTAL - 1);
  localparam count_t ONE    = count_t'(1);

  count_t hcnt_q, hcnt_d;
  count_t vcnt_q, vcnt_d;
  logic   hblank_q, hblank_d;
  logic   vblank_q, vblank_d;
  logic   hsync_n_q, hsync_n_d;
  logic   vsync_n_q, vsync_n_d;
  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;

  // Blank and sync are decoded from the next counts so they move on the same
  // edge as the counters rather than one pixel late.
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (i_pix_cen) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d       = '0;
        line_start_d = 1'b1;
        if (vcnt_q == V_LAST) begin
          vcnt_d        = '0;
          frame_start_d = 1'b1;
        end else begin
          vcnt_d = vcnt_q + ONE;
        end
      end else begin
        hcnt_d = hcnt_q + ONE;
      end
      hblank_d  = int'(hcnt_d) >= H_ACTIVE;
      vblank_d  = int'(vcnt_d) >= V_ACTIVE;
      hsync_n_d = !in_window(hcnt_d, H_SYNC_START, H_SYNC_LEN);
      vsync_n_d = !in_window(vcnt_d, V_SYNC_START, V_SYNC_LEN);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  xsleena_cen_monitor #(
    .CEN_PERIOD  (CEN_PERIOD),
    .CEN_TIMEOUT (CEN_TIMEOUT)
  ) u_cen_monitor (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_pix_cen   (i_pix_cen),
    .o_cen_err   (o_cen_err),
    .o_cen_fault (o_cen_fault)
  );

  assign o_hcnt        = hcnt_q;
  assign o_vcnt        = vcnt_q;
  assign o_hblank      = hblank_q;
  assign o_vblank      = vblank_q;
  assign o_hsync_n     = hsync_n_q;
  assign o_vsync_n     = vsync_n_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_xsleena_video_timing.sv
// Scoreboard bench: a full-size raster with a 1-in-8 enable, and a tiny raster
// with the enable tied high to cover whole frames quickly.
module tb_xsleena_video_timing;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic       hb;
    logic       vb;
    logic       hs_n;
    logic       vs_n;
    logic       ls;
    logic       fs;
  } raster_t;

  localparam raster_t RESET_R = '{h: 9'd0, v: 9'd0, hb: 1'b0, vb: 1'b0,
                                  hs_n: 1'b1, vs_n: 1'b1, ls: 1'b0, fs: 1'b0};

  logic clk = 1'b0;
  logic rst_n, rst_b_n, pix_cen;

  logic [8:0] a_hcnt, a_vcnt, b_hcnt, b_vcnt;
  logic a_hblank, a_vblank, a_hsync_n, a_vsync_n, a_line_start, a_frame_start, a_cen_err, a_cen_fault;
  logic b_hblank, b_vblank, b_hsync_n, b_vsync_n, b_line_start, b_frame_start, b_cen_err, b_cen_fault;

  raster_t qa[$];
  raster_t qb[$];
  int errors = 0;
  int checks = 0;
  int exp_h, exp_v, bh, bv;
  int err_pulses = 0, ls_pulses = 0, fs_pulses = 0, ls_b = 0, fs_b = 0;

  always #5 clk = ~clk;

  xsleena_video_timing dut_a (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pix_cen     (pix_cen),
    .o_hcnt        (a_hcnt),
    .o_vcnt        (a_vcnt),
    .o_hblank      (a_hblank),
    .o_vblank      (a_vblank),
    .o_hsync_n     (a_hsync_n),
    .o_vsync_n     (a_vsync_n),
    .o_line_start  (a_line_start),
    .o_frame_start (a_frame_start),
    .o_cen_err     (a_cen_err),
    .o_cen_fault   (a_cen_fault)
  );

  xsleena_video_timing #(
    .H_TOTAL(16), .H_ACTIVE(10), .H_SYNC_START(12), .H_SYNC_LEN(2),
    .V_TOTAL(12), .V_ACTIVE(8),  .V_SYNC_START(9),  .V_SYNC_LEN(2),
    .CEN_PERIOD(1), .CEN_TIMEOUT(4)
  ) dut_b (
    .i_clk         (clk),
    .i_rst_n       (rst_b_n),
    .i_pix_cen     (1'b1),
    .o_hcnt        (b_hcnt),
    .o_vcnt        (b_vcnt),
    .o_hblank      (b_hblank),
    .o_vblank      (b_vblank),
    .o_hsync_n     (b_hsync_n),
    .o_vsync_n     (b_vsync_n),
    .o_line_start  (b_line_start),
    .o_frame_start (b_frame_start),
    .o_cen_err     (b_cen_err),
    .o_cen_fault   (b_cen_fault)
  );

  function automatic raster_t modelA(input int h, input int v);
    raster_t r;
    r.h    = 9'(h);
    r.v    = 9'(v);
    r.hb   = (h >= 256);
    r.vb   = (v >= 240);
    r.hs_n = !(h >= 304 && h < 336);
    r.vs_n = !(v >= 248 && v < 256);
    r.ls   = (h == 0);
    r.fs   = (h == 0 && v == 0);
    return r;
  endfunction

  function automatic raster_t modelB(input int h, input int v);
    raster_t r;
    r.h    = 9'(h);
    r.v    = 9'(v);
    r.hb   = (h >= 10);
    r.vb   = (v >= 8);
    r.hs_n = !(h == 12 || h == 13);
    r.vs_n = !(v == 9 || v == 10);
    r.ls   = (h == 0);
    r.fs   = (h == 0 && v == 0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // One clock of stimulus; an accepted enable pushes the expected raster.
  task automatic applyStimulus(input logic cen);
    pix_cen = cen;
    if (cen && rst_n) begin
      exp_h = (exp_h + 1) % 384;
      if (exp_h == 0) exp_v = (exp_v + 1) % 272;
      qa.push_back(modelA(exp_h, exp_v));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendCens(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1);
      repeat (period - 1) applyStimulus(1'b0);
    end
  endtask

  task automatic doReset();
    pix_cen = 1'b0;
    rst_n   = 1'b0;
    qa.delete();
    exp_h = 0;
    exp_v = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    err_pulses = 0;
    ls_pulses  = 0;
    fs_pulses  = 0;
  endtask

  always @(negedge clk) begin
    if (a_cen_err) err_pulses++;
    if (a_line_start) ls_pulses++;
    if (a_frame_start) fs_pulses++;
    if (b_line_start) ls_b++;
    if (b_frame_start) fs_b++;
  end

  // Monitor A: pops on every accepted enable, otherwise expects a hold with strobes low.
  initial begin : mon_a
    raster_t cur;
    bit seen;
    cur = RESET_R;
    forever begin
      @(posedge clk);
      seen = pix_cen && rst_n;
      @(negedge clk);
      if (!rst_n) begin
        cur = RESET_R;
      end else if (seen) begin
        if (qa.size() == 0) checkOutput("scoreboard_a_underrun", 0, 1);
        else cur = qa.pop_front();
      end else begin
        cur.ls = 1'b0;
        cur.fs = 1'b0;
      end
      checkOutput("raster_a", int'({a_hcnt, a_vcnt, a_hblank, a_vblank, a_hsync_n,
                                     a_vsync_n, a_line_start, a_frame_start}), int'(cur));
    end
  end

  // Monitor B: enable is tied high, so every edge out of reset produces a new raster.
  initial begin : mon_b
    raster_t cur;
    bit seen;
    forever begin
      @(posedge clk);
      seen = rst_b_n;
      @(negedge clk);
      if (seen && rst_b_n) begin
        if (qb.size() == 0) begin
          checkOutput("scoreboard_b_underrun", 0, 1);
        end else begin
          cur = qb.pop_front();
          checkOutput("raster_b", int'({b_hcnt, b_vcnt, b_hblank, b_vblank, b_hsync_n,
                                         b_vsync_n, b_line_start, b_frame_start}), int'(cur));
          checkOutput("cen_err_b", int'(b_cen_err), 0);
          checkOutput("cen_fault_b", int'(b_cen_fault), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    rst_n   = 1'b0;
    rst_b_n = 1'b0;
    pix_cen = 1'b0;
    exp_h   = 0;
    exp_v   = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hcnt", int'(a_hcnt), 0);
    checkOutput("rst_vcnt", int'(a_vcnt), 0);
    checkOutput("rst_hblank", int'(a_hblank), 0);
    checkOutput("rst_vblank", int'(a_vblank), 0);
    checkOutput("rst_hsync_n", int'(a_hsync_n), 1);
    checkOutput("rst_vsync_n", int'(a_vsync_n), 1);
    checkOutput("rst_line_start", int'(a_line_start), 0);
    checkOutput("rst_frame_start", int'(a_frame_start), 0);
    checkOutput("rst_cen_err", int'(a_cen_err), 0);
    checkOutput("rst_cen_fault", int'(a_cen_fault), 0);

    // One full line at the nominal enable rate
    doReset();
    applyStimulus(1'b0);
    sendCens(384, 8);
    checkOutput("line_hcnt", int'(a_hcnt), 0);
    checkOutput("line_vcnt", int'(a_vcnt), 1);
    checkOutput("line_start_pulses", ls_pulses, 1);
    checkOutput("line_frame_pulses", fs_pulses, 0);
    checkOutput("line_err_pulses", err_pulses, 0);
    checkOutput("line_fault", int'(a_cen_fault), 0);

    // One short interval of 7 clocks
    doReset();
    sendCens(3, 8);
    sendCens(1, 7);
    applyStimulus(1'b1);
    checkOutput("drift_err_pulse", int'(a_cen_err), 1);
    checkOutput("drift_fault", int'(a_cen_fault), 1);
    applyStimulus(1'b0);
    checkOutput("drift_err_clear", int'(a_cen_err), 0);
    repeat (6) applyStimulus(1'b0);
    sendCens(4, 8);
    checkOutput("drift_err_pulses", err_pulses, 1);
    checkOutput("drift_hcnt", int'(a_hcnt), 9);
    checkOutput("drift_fault_sticky", int'(a_cen_fault), 1);

    // Stall: 63 idle cycles are tolerated, the 64th declares a fault
    doReset();
    applyStimulus(1'b1);
    repeat (63) applyStimulus(1'b0);
    checkOutput("stall_fault_63", int'(a_cen_fault), 0);
    checkOutput("stall_hcnt_63", int'(a_hcnt), 1);
    applyStimulus(1'b0);
    checkOutput("stall_fault_64", int'(a_cen_fault), 1);
    checkOutput("stall_hcnt_64", int'(a_hcnt), 1);
    checkOutput("stall_vcnt_64", int'(a_vcnt), 0);
    sendCens(8, 8);
    checkOutput("stall_fault_resume", int'(a_cen_fault), 1);
    checkOutput("stall_hcnt_resume", int'(a_hcnt), 9);

    // Fast-forward to hcnt=200, vcnt=100 then reset mid-line
    doReset();
    repeat (100 * 384 + 200) applyStimulus(1'b1);
    checkOutput("ff_hcnt", int'(a_hcnt), 200);
    checkOutput("ff_vcnt", int'(a_vcnt), 100);
    checkOutput("ff_fault", int'(a_cen_fault), 1);
    #2;
    pix_cen = 1'b0;
    rst_n   = 1'b0;
    qa.delete();
    exp_h = 0;
    exp_v = 0;
    #1;
    checkOutput("async_rst_hcnt", int'(a_hcnt), 0);
    checkOutput("async_rst_vcnt", int'(a_vcnt), 0);
    checkOutput("async_rst_fault", int'(a_cen_fault), 0);
    checkOutput("async_rst_hsync_n", int'(a_hsync_n), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1);
    checkOutput("post_rst_hcnt", int'(a_hcnt), 1);
    checkOutput("post_rst_err", int'(a_cen_err), 0);
    applyStimulus(1'b0);
    checkOutput("post_rst_fault", int'(a_cen_fault), 0);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_a_drained", qa.size(), 0);

    // Tiny raster, enable tied high, CEN_PERIOD=1: two frames plus change
    @(posedge clk);
    #1;
    ls_b    = 0;
    fs_b    = 0;
    bh      = 0;
    bv      = 0;
    rst_b_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bh = (bh + 1) % 16;
      if (bh == 0) bv = (bv + 1) % 12;
      qb.push_back(modelB(bh, bv));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    checkOutput("b_frame_pulses", fs_b, 2);
    checkOutput("b_line_pulses", ls_b, 25);
    checkOutput("scoreboard_b_drained", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
